// File: rtl/bus_port_mux_pkg.sv
// Shared types and constants for the bus port multiplexer: the FSM state
// encoding, the data returned on a timed-out transaction and the default
// response timeout.
package bus_port_mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_RSP = 2'd2
  } state_e;

  // Read data returned on a timed-out transaction (truncated to DATA_WIDTH at use).
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/bus_port_mux_timeout.sv
// Response timeout counter for bus_port_mux. It counts cycles while run_i is
// high and raises expired_o once TIMEOUT_CYCLES cycles have elapsed since
// run_i rose. The count restarts from zero every time run_i rises. Only
// instantiated when BUS_PORT_MUX_TIMEOUT_EN is defined.
module bus_port_mux_timeout
  import bus_port_mux_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic run_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count up while running and saturate at the limit; idle cycles clear the count.
  // NOTE: combinational blocks assign a default first so no path can infer a latch.
  always_comb begin
    cnt_d = '0;
    if (run_i) begin
      cnt_d = (cnt_q == LIMIT) ? cnt_q : cnt_q + 1'b1;
    end
  end

  // Counter register.
  // NOTE: clocked blocks use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = run_i && (cnt_q == LIMIT);

endmodule

// File: rtl/bus_port_mux.sv
// Multiplexes PORT_COUNT requesting ports onto one downstream request/response
// channel with a single outstanding transaction. Port selection is done by an
// external round-robin arbiter: this block publishes the requesting ports on
// arb_ready_list_o while idle and accepts the port named by arb_selected_id_i.
// Optional feature: define BUS_PORT_MUX_TIMEOUT_EN to terminate a transaction
// with an error response after TIMEOUT_CYCLES cycles in WAIT_RSP.
module bus_port_mux
  import bus_port_mux_pkg::*;
#(
  parameter int PORT_COUNT     = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int PORT_ID_WIDTH  = $clog2(PORT_COUNT)
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic [PORT_COUNT-1:0]                 req_valid_i,
  input  logic [PORT_COUNT-1:0][ADDR_WIDTH-1:0] req_addr_i,
  input  logic [PORT_COUNT-1:0]                 req_we_i,
  input  logic [PORT_COUNT-1:0][DATA_WIDTH-1:0] req_wdata_i,
  output logic [PORT_COUNT-1:0]                 req_ready_o,
  output logic [PORT_COUNT-1:0]                 rsp_valid_o,
  output logic [DATA_WIDTH-1:0]                 rsp_rdata_o,
  output logic                                  rsp_err_o,
  output logic [PORT_COUNT-1:0]                 arb_ready_list_o,
  input  logic [PORT_ID_WIDTH-1:0]              arb_selected_id_i,
  output logic                                  m_req_valid_o,
  input  logic                                  m_req_ready_i,
  output logic [ADDR_WIDTH-1:0]                 m_addr_o,
  output logic                                  m_we_o,
  output logic [DATA_WIDTH-1:0]                 m_wdata_o,
  input  logic                                  m_rsp_valid_i,
  input  logic [DATA_WIDTH-1:0]                 m_rdata_i
);

  state_e                   state_q, state_d;
  logic [PORT_ID_WIDTH-1:0] owner_q, owner_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic                     we_q, we_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;

  logic sel_in_range_w;
  logic grant_w;
  logic wait_done_w;

  // The arbiter's choice is only honoured if it names a real port that is still requesting.
  assign sel_in_range_w = int'(arb_selected_id_i) < PORT_COUNT;
  assign grant_w        = !reset_i && (state_q == ST_IDLE) && sel_in_range_w &&
                          req_valid_i[arb_selected_id_i];

`ifdef BUS_PORT_MUX_TIMEOUT_EN
  localparam logic [DATA_WIDTH-1:0] ERR_DATA_W = DATA_WIDTH'(ERR_DATA);

  logic timeout_w;

  bus_port_mux_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .run_i    (state_q == ST_WAIT_RSP),
    .expired_o(timeout_w)
  );

  assign wait_done_w = m_rsp_valid_i || timeout_w;
`else
  assign wait_done_w = m_rsp_valid_i;
`endif

  // State and transaction registers; the payload is captured only on a grant.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
    end
  end

  // Next state: grant in IDLE, hand off in ISSUE, finish on response (or timeout).
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_w) begin
          state_d = ST_ISSUE;
          owner_d = arb_selected_id_i;
          addr_d  = req_addr_i[arb_selected_id_i];
          we_d    = req_we_i[arb_selected_id_i];
          wdata_d = req_wdata_i[arb_selected_id_i];
        end
      end
      ST_ISSUE: begin
        if (m_req_ready_i) begin
          state_d = ST_WAIT_RSP;
        end
      end
      ST_WAIT_RSP: begin
        if (wait_done_w) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: all handshakes are combinational from state; a real response beats a timeout.
  always_comb begin
    req_ready_o      = '0;
    rsp_valid_o      = '0;
    rsp_rdata_o      = '0;
    rsp_err_o        = 1'b0;
    arb_ready_list_o = '0;
    m_req_valid_o    = 1'b0;
    if (!reset_i) begin
      case (state_q)
        ST_IDLE: begin
          arb_ready_list_o = req_valid_i;
          if (grant_w) begin
            req_ready_o[arb_selected_id_i] = 1'b1;
          end
        end
        ST_ISSUE: begin
          m_req_valid_o = 1'b1;
        end
        ST_WAIT_RSP: begin
          if (m_rsp_valid_i) begin
            rsp_valid_o[owner_q] = 1'b1;
            rsp_rdata_o          = m_rdata_i;
          end
`ifdef BUS_PORT_MUX_TIMEOUT_EN
          else if (timeout_w) begin
            rsp_valid_o[owner_q] = 1'b1;
            rsp_rdata_o          = ERR_DATA_W;
            rsp_err_o            = 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  // Payload registers are zero in reset, so the downstream bus reads zero too.
  assign m_addr_o  = addr_q;
  assign m_we_o    = we_q;
  assign m_wdata_o = wdata_q;

endmodule

// File: tb/tb_bus_port_mux.sv
// Self-checking bench for bus_port_mux. Directed cycle-exact scenarios cover
// the single request, backpressure, reset mid-transaction and response wait
// (timeout when BUS_PORT_MUX_TIMEOUT_EN is defined). A randomized phase runs
// per-port request queues through a bench round-robin arbiter; a reference
// model precomputes the grant order, and a monitor scoreboard compares.
module tb_bus_port_mux;

  localparam int P    = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int IDW  = 2;
  localparam int TMO  = 8;
  localparam int HALF = 5;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
  } txn_t;

  typedef struct packed {
    logic [P-1:0]  onehot;
    logic [DW-1:0] rdata;
    logic          err;
  } rsp_t;

  logic                   clk;
  logic                   reset_i;
  logic [P-1:0]           req_valid_i;
  logic [P-1:0][AW-1:0]   req_addr_i;
  logic [P-1:0]           req_we_i;
  logic [P-1:0][DW-1:0]   req_wdata_i;
  logic [P-1:0]           req_ready_o;
  logic [P-1:0]           rsp_valid_o;
  logic [DW-1:0]          rsp_rdata_o;
  logic                   rsp_err_o;
  logic [P-1:0]           arb_ready_list_o;
  logic [IDW-1:0]         arb_selected_id_i;
  logic                   m_req_valid_o;
  logic                   m_req_ready_i;
  logic [AW-1:0]          m_addr_o;
  logic                   m_we_o;
  logic [DW-1:0]          m_wdata_o;
  logic                   m_rsp_valid_i;
  logic [DW-1:0]          m_rdata_i;

  bus_port_mux #(
    .PORT_COUNT    (P),
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TMO),
    .PORT_ID_WIDTH (IDW)
  ) dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .req_valid_i      (req_valid_i),
    .req_addr_i       (req_addr_i),
    .req_we_i         (req_we_i),
    .req_wdata_i      (req_wdata_i),
    .req_ready_o      (req_ready_o),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_rdata_o      (rsp_rdata_o),
    .rsp_err_o        (rsp_err_o),
    .arb_ready_list_o (arb_ready_list_o),
    .arb_selected_id_i(arb_selected_id_i),
    .m_req_valid_o    (m_req_valid_o),
    .m_req_ready_i    (m_req_ready_i),
    .m_addr_o         (m_addr_o),
    .m_we_o           (m_we_o),
    .m_wdata_o        (m_wdata_o),
    .m_rsp_valid_i    (m_rsp_valid_i),
    .m_rdata_i        (m_rdata_i)
  );

  initial clk = 1'b0;
  always #HALF clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- external round-robin arbiter (environment) ----------------
  logic [IDW-1:0] arb_last_q;
  logic [IDW-1:0] arb_sel;

  always_comb begin
    arb_sel = arb_last_q + 1'b1;
    for (int k = P; k >= 1; k--) begin
      if (arb_ready_list_o[(int'(arb_last_q) + k) % P]) arb_sel = IDW'((int'(arb_last_q) + k) % P);
    end
  end

  always @(posedge clk or posedge reset_i) begin
    if (reset_i) arb_last_q <= IDW'(P - 1);
    else if (arb_ready_list_o != '0) arb_last_q <= arb_sel;
  end

  assign arb_selected_id_i = arb_sel;

  // ---------------- scoreboard ----------------
  int   exp_grant[$];
  txn_t exp_issue[$];
  rsp_t exp_rsp[$];
  int   order_port[$];
  txn_t pend[P][$];
  bit   sb_en = 1'b0;
  int   rsp_seen = 0;
  int   total = 0;

  int   mon_g;
  txn_t mon_t;
  rsp_t mon_r;

  always @(negedge clk) begin
    if (sb_en && !reset_i) begin
      if (req_ready_o != '0) begin
        if (exp_grant.size() == 0) check("sb_grant_extra", req_ready_o, 0);
        else begin
          mon_g = exp_grant.pop_front();
          check("sb_grant", req_ready_o, 64'(1) << mon_g);
        end
      end
      if (m_req_valid_o && m_req_ready_i) begin
        if (exp_issue.size() == 0) check("sb_issue_extra", m_req_valid_o, 0);
        else begin
          mon_t = exp_issue.pop_front();
          check("sb_addr", m_addr_o, mon_t.addr);
          check("sb_we", m_we_o, mon_t.we);
          check("sb_wdata", m_wdata_o, mon_t.wdata);
        end
      end
      if (rsp_valid_o != '0) begin
        if (exp_rsp.size() == 0) check("sb_rsp_extra", rsp_valid_o, 0);
        else begin
          mon_r = exp_rsp.pop_front();
          check("sb_rsp_port", rsp_valid_o, mon_r.onehot);
          check("sb_rsp_data", rsp_rdata_o, mon_r.rdata);
          check("sb_rsp_err", rsp_err_o, mon_r.err);
          rsp_seen++;
        end
      end else begin
        check("sb_idle_rdata", {rsp_err_o, rsp_rdata_o}, 0);
      end
      if (m_req_valid_o) check("sb_list_busy", arb_ready_list_o, 0);
    end
  end

  // ---------------- helpers ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    req_valid_i   = '0;
    req_addr_i    = '0;
    req_we_i      = '0;
    req_wdata_i   = '0;
    m_req_ready_i = 1'b0;
    m_rsp_valid_i = 1'b0;
    m_rdata_i     = '0;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    reset_i = 1'b0;
  endtask

  // Grant port 0, stall n_wait cycles in WAIT_RSP, then either respond or let the timeout fire.
  task automatic wait_case(input string tag, input int n_wait, input bit real_rsp,
                           input logic [31:0] data);
    logic [31:0] exp_data;
    exp_data = real_rsp ? data : 32'hDEAD_BEEF;
    next_cycle();
    req_valid_i = 4'b0001; req_addr_i[0] = 32'h40; req_we_i[0] = 1'b0; m_req_ready_i = 1'b1;
    @(negedge clk); check({tag, "_grant"}, req_ready_o, 4'b0001);
    next_cycle();
    req_valid_i = '0;
    @(negedge clk); check({tag, "_issue"}, m_req_valid_o, 1);
    next_cycle();
    m_req_ready_i = 1'b0;
    for (int i = 0; i < n_wait; i++) begin
      @(negedge clk); check({tag, "_quiet"}, rsp_valid_o, 0);
      next_cycle();
    end
    m_rsp_valid_i = real_rsp; m_rdata_i = data;
    @(negedge clk);
    check({tag, "_rsp_valid"}, rsp_valid_o, 4'b0001);
    check({tag, "_rsp_data"}, rsp_rdata_o, exp_data);
    check({tag, "_rsp_err"}, rsp_err_o, !real_rsp);
    next_cycle();
    m_rsp_valid_i = 1'b0; m_rdata_i = '0;
    @(negedge clk); check({tag, "_done"}, rsp_valid_o, 0);
  endtask

  // Reference model: per-port queues served round-robin, starting after port P-1.
  task automatic build_random();
    int   left[P];
    int   idx[P];
    int   last;
    txn_t t;
    total = 0;
    last  = P - 1;
    for (int p = 0; p < P; p++) begin
      left[p] = $urandom_range(3, 7);
      idx[p]  = 0;
      pend[p].delete();
      for (int i = 0; i < left[p]; i++) begin
        t.addr  = $urandom;
        t.we    = 1'($urandom_range(0, 1));
        t.wdata = $urandom;
        pend[p].push_back(t);
      end
      total += left[p];
    end
    for (int n = 0; n < total; n++) begin
      int pick;
      pick = -1;
      for (int k = 1; k <= P; k++) begin
        if (pick < 0 && left[(last + k) % P] > 0) pick = (last + k) % P;
      end
      exp_grant.push_back(pick);
      exp_issue.push_back(pend[pick][idx[pick]]);
      order_port.push_back(pick);
      idx[pick]++;
      left[pick]--;
      last = pick;
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached with %0d of %0d responses", rsp_seen, total);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [P-1:0] gr;
    bit   iss, drove, pending;
    int   delay, rsp_k;
    rsp_t r;

    reset_i = 1'b1;
    drive_idle();
    req_valid_i = 4'b1111;
    @(negedge clk);
    check("rst_list", arb_ready_list_o, 0);
    check("rst_ready", req_ready_o, 0);
    check("rst_mvalid", m_req_valid_o, 0);
    check("rst_payload", {m_addr_o, m_we_o}, 0);
    check("rst_wdata", m_wdata_o, 0);
    check("rst_rsp", {rsp_valid_o, rsp_err_o, rsp_rdata_o}, 0);
    do_reset();

    // Single request from port 2.
    next_cycle();
    req_valid_i = 4'b0100; req_addr_i[2] = 32'h100; req_we_i[2] = 1'b0; m_req_ready_i = 1'b1;
    @(negedge clk);
    check("t1_grant", req_ready_o, 4'b0100);
    check("t1_list", arb_ready_list_o, 4'b0100);
    check("t1_mvalid_c0", m_req_valid_o, 0);
    next_cycle();
    req_valid_i = '0; req_addr_i[2] = 32'hFFFF_FFFF;
    @(negedge clk);
    check("t1_mvalid_c1", m_req_valid_o, 1);
    check("t1_maddr", m_addr_o, 32'h100);
    check("t1_mwe", m_we_o, 0);
    check("t1_ready_c1", req_ready_o, 0);
    check("t1_list_c1", arb_ready_list_o, 0);
    next_cycle();
    m_req_ready_i = 1'b0; m_rsp_valid_i = 1'b1; m_rdata_i = 32'h1234;
    @(negedge clk);
    check("t1_rsp_valid", rsp_valid_o, 4'b0100);
    check("t1_rsp_data", rsp_rdata_o, 32'h1234);
    check("t1_rsp_err", rsp_err_o, 0);
    next_cycle();
    m_rsp_valid_i = 1'b0; m_rdata_i = 32'hAAAA_AAAA;
    @(negedge clk);
    check("t1_after_valid", rsp_valid_o, 0);
    check("t1_after_data", rsp_rdata_o, 0);

    // Backpressure on port 1 with all ports requesting during the stall.
    next_cycle();
    req_valid_i = 4'b0010; req_addr_i[1] = 32'hCAFE_0010; req_we_i[1] = 1'b1;
    req_wdata_i[1] = 32'h1111_2222; m_req_ready_i = 1'b0;
    @(negedge clk); check("bp_grant", req_ready_o, 4'b0010);
    next_cycle();
    req_valid_i = 4'b1111; req_addr_i[1] = '0; req_wdata_i[1] = '0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) next_cycle();
      @(negedge clk);
      check("bp_mvalid", m_req_valid_o, 1);
      check("bp_addr", m_addr_o, 32'hCAFE_0010);
      check("bp_wdata", m_wdata_o, 32'h1111_2222);
      check("bp_we", m_we_o, 1);
      check("bp_no_grant", req_ready_o, 0);
      check("bp_list", arb_ready_list_o, 0);
    end
    next_cycle();
    m_req_ready_i = 1'b1;
    @(negedge clk); check("bp_release", m_req_valid_o, 1);
    next_cycle();
    m_req_ready_i = 1'b0; req_valid_i = '0; m_rsp_valid_i = 1'b1; m_rdata_i = 32'h0BAD_F00D;
    @(negedge clk);
    check("bp_rsp_valid", rsp_valid_o, 4'b0010);
    check("bp_rsp_data", rsp_rdata_o, 32'h0BAD_F00D);
    next_cycle();
    m_rsp_valid_i = 1'b0;

`ifdef BUS_PORT_MUX_TIMEOUT_EN
    wait_case("tmo", TMO, 1'b0, 32'h0);
    wait_case("tmo_race", TMO, 1'b1, 32'h5A5A_5A5A);
`else
    wait_case("hang", 20, 1'b1, 32'h0F0F_0F0F);
`endif

    // Reset while waiting for port 3's response.
    next_cycle();
    req_valid_i = 4'b1000; req_addr_i[3] = 32'h300; req_we_i[3] = 1'b1; m_req_ready_i = 1'b1;
    @(negedge clk); check("rs_grant", req_ready_o, 4'b1000);
    next_cycle();
    req_valid_i = 4'b1111;
    @(negedge clk); check("rs_issue", m_req_valid_o, 1);
    next_cycle();
    m_req_ready_i = 1'b0;
    #2;
    reset_i = 1'b1;
    #1;
    check("rs_mvalid", m_req_valid_o, 0);
    check("rs_payload", {m_addr_o, m_we_o}, 0);
    check("rs_list", arb_ready_list_o, 0);
    check("rs_ready", req_ready_o, 0);
    check("rs_rsp", {rsp_valid_o, rsp_err_o, rsp_rdata_o}, 0);
    next_cycle();
    m_rsp_valid_i = 1'b1; m_rdata_i = 32'h7777;
    @(negedge clk);
    check("rs_late_rsp_in_reset", rsp_valid_o, 0);
    next_cycle();
    reset_i = 1'b0; req_valid_i = 4'b0010; req_addr_i[1] = 32'h222; req_we_i[1] = 1'b0;
    @(negedge clk);
    check("rs_late_rsp_ignored", rsp_valid_o, 0);
    check("rs_late_rsp_data", rsp_rdata_o, 0);
    check("rs_idle_list", arb_ready_list_o, 4'b0010);
    check("rs_idle_grant", req_ready_o, 4'b0010);
    next_cycle();
    req_valid_i = '0; m_rsp_valid_i = 1'b0; m_req_ready_i = 1'b1;
    @(negedge clk);
    check("rs_post_issue", m_req_valid_o, 1);
    check("rs_post_addr", m_addr_o, 32'h222);
    next_cycle();
    m_req_ready_i = 1'b0; m_rsp_valid_i = 1'b1; m_rdata_i = 32'h2222;
    @(negedge clk);
    check("rs_post_rsp", rsp_valid_o, 4'b0010);
    check("rs_post_data", rsp_rdata_o, 32'h2222);
    next_cycle();
    drive_idle();

    // Randomized phase against the round-robin reference model.
    do_reset();
    build_random();
    sb_en   = 1'b1;
    gr      = '0;
    iss     = 1'b0;
    drove   = 1'b0;
    pending = 1'b0;
    delay   = 0;
    rsp_k   = 0;
    for (int cyc = 0; cyc < 3000 && rsp_seen < total; cyc++) begin
      next_cycle();
      for (int p = 0; p < P; p++) begin
        if (gr[p] && pend[p].size() > 0) void'(pend[p].pop_front());
      end
      if (drove) pending = 1'b0;
      drove = 1'b0;
      if (iss) begin
        pending = 1'b1;
        delay   = $urandom_range(0, 3);
      end
      for (int p = 0; p < P; p++) begin
        if (pend[p].size() > 0) begin
          req_valid_i[p] = 1'b1;
          req_addr_i[p]  = pend[p][0].addr;
          req_we_i[p]    = pend[p][0].we;
          req_wdata_i[p] = pend[p][0].wdata;
        end else begin
          req_valid_i[p] = 1'b0;
          req_addr_i[p]  = $urandom;
          req_we_i[p]    = 1'($urandom_range(0, 1));
          req_wdata_i[p] = $urandom;
        end
      end
      m_req_ready_i = ($urandom_range(0, 3) != 0);
      m_rdata_i     = $urandom;
      if (pending && delay == 0) begin
        m_rsp_valid_i = 1'b1;
        r.onehot = '0;
        r.onehot[order_port[rsp_k]] = 1'b1;
        r.rdata  = m_rdata_i;
        r.err    = 1'b0;
        exp_rsp.push_back(r);
        rsp_k++;
        drove = 1'b1;
      end else if (pending) begin
        delay--;
        m_rsp_valid_i = 1'b0;
      end else begin
        m_rsp_valid_i = ($urandom_range(0, 3) == 0);
      end
      @(negedge clk);
      gr  = req_ready_o;
      iss = m_req_valid_o && m_req_ready_i;
    end
    sb_en = 1'b0;
    check("rand_all_rsp", rsp_seen, total);
    check("rand_grants_left", exp_grant.size(), 0);
    check("rand_issue_left", exp_issue.size(), 0);
    next_cycle();
    drive_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bus_port_mux.md
BUS_PORT_MUX -- requirements
Module: bus_port_mux

Interface
REQ-001 SHALL have parameters, one per line:
- PORT_COUNT, 4, number of requesting ports.
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.
- TIMEOUT_CYCLES, 255, response timeout in cycles.
- PORT_ID_WIDTH, $clog2(PORT_COUNT), port index width.
REQ-002 SHALL use one clock; reset is asynchronous and active-high.
REQ-003 SHALL have ports, one per line:
- clk_i  in  1  clock.
- reset_i  in  1  async active-high reset.
- req_valid_i  in  PORT_COUNT  per-port request valid.
- req_addr_i  in  PORT_COUNT x ADDR_WIDTH  per-port address.
- req_we_i  in  PORT_COUNT  per-port write enable.
- req_wdata_i  in  PORT_COUNT x DATA_WIDTH  per-port write data.
- req_ready_o  out  PORT_COUNT  one-hot accept pulse.
- rsp_valid_o  out  PORT_COUNT  one-hot response pulse.
- rsp_rdata_o  out  DATA_WIDTH  shared response data.
- rsp_err_o  out  1  response error flag.
- arb_ready_list_o  out  PORT_COUNT  request list to external round-robin arbiter.
- arb_selected_id_i  in  PORT_ID_WIDTH  arbiter's chosen port.
- m_req_valid_o / m_req_ready_i  out/in  1  downstream request handshake.
- m_addr_o, m_we_o, m_wdata_o  out  ADDR_WIDTH/1/DATA_WIDTH  downstream payload.
- m_rsp_valid_i, m_rdata_i  in  1/DATA_WIDTH  downstream response.

Function
REQ-004 SHALL implement FSM IDLE, ISSUE, WAIT_RSP; one outstanding transaction.
REQ-005 IDLE: arb_ready_list_o = req_valid_i; in every other state it SHALL be all-zero, so the arbiter records exactly one grant per transaction.
REQ-006 IDLE with req_valid_i[arb_selected_id_i]=1:
- owner_r <= arb_selected_id_i.
- addr/we/wdata registered from that port.
- req_ready_o[owner] = 1 the same cycle.
- next state ISSUE.
Otherwise stay in IDLE with req_ready_o = 0.
REQ-007 ISSUE: m_req_valid_o = 1 with registered payload held stable; on m_req_ready_i = 1, go to WAIT_RSP.
REQ-008 WAIT_RSP: on m_rsp_valid_i = 1:
- rsp_valid_o[owner_r] = 1 and rsp_rdata_o = m_rdata_i, combinationally, same cycle.
- rsp_err_o = 0.
- next state IDLE.
REQ-009 Latency: grant cycle, then at least 1 ISSUE cycle, then at least 1 WAIT_RSP cycle; minimum 3 cycles per transaction; re-grant no earlier than the cycle after the response.
REQ-010 req_ready_o and rsp_valid_o SHALL be zero or one-hot, never for a non-owner port.
REQ-011 rsp_rdata_o SHALL be 0 whenever no rsp_valid_o bit is set.
REQ-012 A port that drops req_valid_i before its grant is not accepted. Its payload after grant is ignored.
REQ-013 m_rsp_valid_i outside WAIT_RSP SHALL be ignored.

Reset
REQ-014 reset_i SHALL asynchronously force:
- state IDLE, owner_r = 0, payload registers = 0, timer = 0.
- all outputs 0, including m_req_valid_o and arb_ready_list_o.
REQ-015 Reset mid-transaction SHALL abandon it with no response pulse; the first post-reset cycle is IDLE.

Configuration
REQ-016 Macro BUS_PORT_MUX_TIMEOUT_EN defined: a counter runs in WAIT_RSP. When it reaches TIMEOUT_CYCLES:
- rsp_valid_o[owner_r] = 1, rsp_err_o = 1, rsp_rdata_o = ERR_DATA (0xDEAD_BEEF truncated to DATA_WIDTH).
- next state IDLE.
- If m_rsp_valid_i arrives the same cycle, the real response wins with rsp_err_o = 0.
- The counter clears on WAIT_RSP entry.
REQ-017 Macro undefined: no counter logic; rsp_err_o tied 0; WAIT_RSP waits indefinitely.

Structure
REQ-018 Package bus_port_mux_pkg SHALL hold the state enum, ERR_DATA and the default TIMEOUT_CYCLES constant.
REQ-019 The timeout counter SHALL be sub-module bus_port_mux_timeout, instantiated only under BUS_PORT_MUX_TIMEOUT_EN.
REQ-020 The arbiter SHALL stay external, wired via arb_ready_list_o / arb_selected_id_i.

Verification
REQ-021 Single request: port 2 req with addr 0x100, m_req_ready_i=1 immediately, response 1 cycle later with rdata 0x1234 -> req_ready_o=0b0100 at cycle 0, m_req_valid_o at cycle 1, rsp_valid_o=0b0100 with rdata 0x1234 at cycle 2.
REQ-022 All 4 ports requesting continuously -> grants rotate 0,1,2,3,0; every port served once per 4 transactions.
REQ-023 Backpressure: m_req_ready_i low for 5 cycles -> m_req_valid_o and payload stable all 5 cycles; no new grant issued.
REQ-024 Reset asserted in WAIT_RSP -> all outputs 0 immediately; no rsp_valid_o pulse; a late m_rsp_valid_i is ignored.
REQ-025 With BUS_PORT_MUX_TIMEOUT_EN and TIMEOUT_CYCLES=8, no response -> rsp_err_o=1 with rdata 0xDEADBEEF 8 cycles after WAIT_RSP entry. A response in that same cycle -> rsp_err_o=0 with the real data.
